// File: rtl/priority_decoder.sv
// priority_decoder
// Receive-side companion to the priority encoder. Takes the encoder's one-hot
// leftmost/rightmost vectors, turns them into binary indices, a span count and
// a contiguous range mask. Every beat is checked for a malformed one-hot pair,
// and errored beats are counted in a saturating counter. Two register stages,
// one beat per cycle, no backpressure.
//
// Ports:
//   clk_i          rising-edge clock
//   srst_i         synchronous reset, active-low
//   data_left_i    one-hot of the most-significant set bit (or zero)
//   data_right_i   one-hot of the least-significant set bit (or zero)
//   data_val_i     input beat qualifier
//   idx_left_o     binary index of the left bit
//   idx_right_o    binary index of the right bit
//   count_o        idx_left - idx_right + 1 (0 for empty/errored beats)
//   range_mask_o   ones from idx_right through idx_left inclusive
//   empty_o        beat carried two all-zero vectors
//   err_o          beat was malformed
//   data_val_o     output qualifier
//   err_cnt_o      saturating count of errored valid beats
module priority_decoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic [IDX_W-1:0] idx_left_o,
  output logic [IDX_W-1:0] idx_right_o,
  output logic [IDX_W:0]   count_o,
  output logic [WIDTH-1:0] range_mask_o,
  output logic             empty_o,
  output logic             err_o,
  output logic             data_val_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    BEAT_NORMAL,
    BEAT_EMPTY,
    BEAT_ERR
  } beat_e;

  // Stage 1: input capture. Data is registered every cycle; only the valid
  // is cleared by reset since data without a valid is ignored downstream.
  logic [WIDTH-1:0] s1_left;
  logic [WIDTH-1:0] s1_right;
  logic             s1_val;

  always_ff @(posedge clk_i) begin
    s1_left  <= data_left_i;
    s1_right <= data_right_i;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      s1_val <= 1'b0;
    end else begin
      s1_val <= data_val_i;
    end
  end

  // One-hot to binary: each index bit is the OR of all input bits whose
  // position has that bit set. Multi-hot inputs produce garbage here, which
  // the classification below catches.
  logic [IDX_W-1:0] idx_l;
  logic [IDX_W-1:0] idx_r;

  always_comb begin
    idx_l = '0;
    idx_r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s1_left[i])  idx_l = idx_l | i[IDX_W-1:0];
      if (s1_right[i]) idx_r = idx_r | i[IDX_W-1:0];
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
  logic multi_l;
  logic multi_r;
  logic zero_l;
  logic zero_r;

  assign multi_l = |(s1_left  & (s1_left  - ONE));
  assign multi_r = |(s1_right & (s1_right - ONE));
  assign zero_l  = (s1_left  == '0);
  assign zero_r  = (s1_right == '0);

  // Bits strictly below right, and bits up to and including left.
  // left | (left - 1) equals (left << 1) - 1 for a one-hot left, but never
  // needs the extra carry bit when left is the top bit.
  logic [WIDTH-1:0] below_r;
  logic [WIDTH-1:0] upto_l;
  logic [WIDTH-1:0] mask;
  logic [IDX_W:0]   span;

  assign below_r = s1_right - ONE;
  assign upto_l  = s1_left | (s1_left - ONE);
  assign mask    = upto_l & ~below_r;
  assign span    = ({1'b0, idx_l} - {1'b0, idx_r}) + (IDX_W+1)'(1);

  beat_e beat;

  always_comb begin
    beat = BEAT_NORMAL;
    if (multi_l || multi_r || (zero_l != zero_r) || (idx_l < idx_r)) begin
      beat = BEAT_ERR;
    end else if (zero_l) begin
      beat = BEAT_EMPTY;
    end
  end

  // Stage 2: outputs update only on a valid beat and hold otherwise.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      idx_left_o   <= '0;
      idx_right_o  <= '0;
      count_o      <= '0;
      range_mask_o <= '0;
      empty_o      <= 1'b0;
      err_o        <= 1'b0;
      data_val_o   <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      data_val_o <= s1_val;
      if (s1_val) begin
        unique case (beat)
          BEAT_NORMAL: begin
            idx_left_o   <= idx_l;
            idx_right_o  <= idx_r;
            count_o      <= span;
            range_mask_o <= mask;
            empty_o      <= 1'b0;
            err_o        <= 1'b0;
          end
          BEAT_EMPTY: begin
            idx_left_o   <= '0;
            idx_right_o  <= '0;
            count_o      <= '0;
            range_mask_o <= '0;
            empty_o      <= 1'b1;
            err_o        <= 1'b0;
          end
          default: begin
            idx_left_o   <= '0;
            idx_right_o  <= '0;
            count_o      <= '0;
            range_mask_o <= '0;
            empty_o      <= 1'b0;
            err_o        <= 1'b1;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Testbench for priority_decoder: directed table, hand-written reset and
// saturation sequences, and randomized streaming against a reference model.
module tb_priority_decoder;

  logic        clk;
  logic        srst;
  logic [15:0] dl;
  logic [15:0] dr;
  logic        dvi;

  logic [3:0]  idxl, idxr;
  logic [4:0]  cnt;
  logic [15:0] mask;
  logic        empty, err, dvo;
  logic [15:0] ecnt;

  logic [3:0]  idxl_s, idxr_s;
  logic [4:0]  cnt_s;
  logic [15:0] mask_s;
  logic        empty_s, err_s, dvo_s;
  logic [3:0]  ecnt_s;

  priority_decoder #(.WIDTH(16), .CNT_W(16)) dut (
    .clk_i(clk), .srst_i(srst),
    .data_left_i(dl), .data_right_i(dr), .data_val_i(dvi),
    .idx_left_o(idxl), .idx_right_o(idxr), .count_o(cnt),
    .range_mask_o(mask), .empty_o(empty), .err_o(err),
    .data_val_o(dvo), .err_cnt_o(ecnt)
  );

  priority_decoder #(.WIDTH(16), .CNT_W(4)) dut_sat (
    .clk_i(clk), .srst_i(srst),
    .data_left_i(dl), .data_right_i(dr), .data_val_i(dvi),
    .idx_left_o(idxl_s), .idx_right_o(idxr_s), .count_o(cnt_s),
    .range_mask_o(mask_s), .empty_o(empty_s), .err_o(err_s),
    .data_val_o(dvo_s), .err_cnt_o(ecnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  il;
    logic [3:0]  ir;
    logic [4:0]  cnt;
    logic [15:0] mask;
    logic        empty;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    exp_t        e;
  } vec_t;

  // Reference model state: what a stage-1 register holds and what the
  // outputs should show, tracked beat by beat.
  logic        m_s1v;
  logic [15:0] m_s1l, m_s1r;
  logic        m_dv;
  exp_t        m_out;
  int          m_cnt, m_cnt4;

  // Decode from the rules: find bit positions by search, mask by range test.
  function automatic exp_t ref_decode(logic [15:0] l, logic [15:0] r);
    exp_t e;
    int il, ir;
    e = '0;
    il = -1;
    ir = -1;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) il = i;
      if (r[i]) ir = i;
    end
    if ($countones(l) > 1 || $countones(r) > 1 || ((l == 0) != (r == 0)) || il < ir) begin
      e.err = 1'b1;
    end else if (l == 0) begin
      e.empty = 1'b1;
    end else begin
      e.il  = il[3:0];
      e.ir  = ir[3:0];
      e.cnt = 5'(il - ir + 1);
      for (int i = 0; i < 16; i++) e.mask[i] = (i >= ir && i <= il);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("data_val", 32'(dvo), 32'(m_dv));
    chk("idx_left", 32'(idxl), 32'(m_out.il));
    chk("idx_right", 32'(idxr), 32'(m_out.ir));
    chk("count", 32'(cnt), 32'(m_out.cnt));
    chk("range_mask", 32'(mask), 32'(m_out.mask));
    chk("empty", 32'(empty), 32'(m_out.empty));
    chk("err", 32'(err), 32'(m_out.err));
    chk("err_cnt", 32'(ecnt), 32'(m_cnt));
    chk("err_cnt_sat", 32'(ecnt_s), 32'(m_cnt4));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic tick(input logic rst, input logic [15:0] l, input logic [15:0] r, input logic v);
    exp_t e;
    srst = rst;
    dl   = l;
    dr   = r;
    dvi  = v;
    @(posedge clk);
    if (!rst) begin
      m_s1v  = 1'b0;
      m_dv   = 1'b0;
      m_out  = '0;
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin
      m_dv = m_s1v;
      if (m_s1v) begin
        e = ref_decode(m_s1l, m_s1r);
        m_out = e;
        if (e.err) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
      end
      m_s1v = v;
      m_s1l = l;
      m_s1r = r;
    end
    #1;
    compare_all();
  endtask

  task automatic gen_good(output logic [15:0] l, output logic [15:0] r);
    int unsigned il, ir;
    ir = $urandom_range(15, 0);
    il = $urandom_range(15, ir);
    l = 16'(1) << il;
    r = 16'(1) << ir;
  endtask

  vec_t tbl [0:7];

  initial begin
    logic [15:0] l, r;
    logic        v;
    int unsigned sel;

    tbl[0] = '{16'h0080, 16'h0004, '{4'd7,  4'd2, 5'd6,  16'h00FC, 1'b0, 1'b0}};
    tbl[1] = '{16'h8000, 16'h0001, '{4'd15, 4'd0, 5'd16, 16'hFFFF, 1'b0, 1'b0}};
    tbl[2] = '{16'h0010, 16'h0010, '{4'd4,  4'd4, 5'd1,  16'h0010, 1'b0, 1'b0}};
    tbl[3] = '{16'h0000, 16'h0000, '{4'd0,  4'd0, 5'd0,  16'h0000, 1'b1, 1'b0}};
    tbl[4] = '{16'h0003, 16'h0001, '{4'd0,  4'd0, 5'd0,  16'h0000, 1'b0, 1'b1}};
    tbl[5] = '{16'h0002, 16'h0008, '{4'd0,  4'd0, 5'd0,  16'h0000, 1'b0, 1'b1}};
    tbl[6] = '{16'h0010, 16'h0000, '{4'd0,  4'd0, 5'd0,  16'h0000, 1'b0, 1'b1}};
    tbl[7] = '{16'h0000, 16'h0100, '{4'd0,  4'd0, 5'd0,  16'h0000, 1'b0, 1'b1}};

    m_s1v = 1'b0; m_s1l = '0; m_s1r = '0;
    m_dv = 1'b0; m_out = '0; m_cnt = 0; m_cnt4 = 0;
    srst = 1'b0; dl = '0; dr = '0; dvi = 1'b0;

    // Reset state
    tick(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    tick(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("reset_val", 32'(dvo), 32'd0);
    chk("reset_cnt", 32'(ecnt), 32'd0);

    // Directed table: one beat, one idle cycle, then check against constants.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, tbl[i].l, tbl[i].r, 1'b1);
      tick(1'b1, 16'hA5A5, 16'h5A5A, 1'b0);
      chk("tbl_val", 32'(dvo), 32'd1);
      chk("tbl_idx_left", 32'(idxl), 32'(tbl[i].e.il));
      chk("tbl_idx_right", 32'(idxr), 32'(tbl[i].e.ir));
      chk("tbl_count", 32'(cnt), 32'(tbl[i].e.cnt));
      chk("tbl_mask", 32'(mask), 32'(tbl[i].e.mask));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e.empty));
      chk("tbl_err", 32'(err), 32'(tbl[i].e.err));
      // Idle cycle afterwards: qualifier drops, data holds.
      tick(1'b1, 16'hFFFF, 16'h0000, 1'b0);
      chk("tbl_gap_val", 32'(dvo), 32'd0);
      chk("tbl_hold_mask", 32'(mask), 32'(tbl[i].e.mask));
    end
    // Four errored beats in the table (entries 4..7).
    chk("tbl_err_cnt", 32'(ecnt), 32'd4);

    // Streaming: 20 back-to-back well-formed beats.
    for (int i = 0; i < 20; i++) begin
      gen_good(l, r);
      tick(1'b1, l, r, 1'b1);
    end
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);

    // Random gaps with mixed beat classes; invalid cycles carry junk.
    for (int i = 0; i < 200; i++) begin
      v = 1'($urandom_range(1, 0));
      sel = $urandom_range(9, 0);
      if (v && sel < 7) begin
        gen_good(l, r);
      end else if (v && sel == 7) begin
        l = '0;
        r = '0;
      end else begin
        l = 16'($urandom);
        r = 16'($urandom);
      end
      tick(1'b1, l, r, v);
    end
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);

    // Mid-stream reset: beats B (in stage 1) and C (at input) are discarded.
    tick(1'b1, 16'h0040, 16'h0002, 1'b1);
    tick(1'b1, 16'h0003, 16'h0001, 1'b1);
    tick(1'b0, 16'h0800, 16'h0008, 1'b1);
    chk("mrst_val", 32'(dvo), 32'd0);
    chk("mrst_mask", 32'(mask), 32'd0);
    chk("mrst_cnt", 32'(ecnt), 32'd0);
    tick(1'b1, 16'h0200, 16'h0020, 1'b1);
    chk("mrst_after_val", 32'(dvo), 32'd0);
    chk("mrst_after_count", 32'(cnt), 32'd0);
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);
    chk("release_val", 32'(dvo), 32'd1);
    chk("release_idx_left", 32'(idxl), 32'd9);
    chk("release_idx_right", 32'(idxr), 32'd5);
    chk("release_count", 32'(cnt), 32'd5);
    chk("release_mask", 32'(mask), 32'h03E0);

    // Saturation: from reset, 20 errored beats.
    tick(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 16'h0003, 16'h0001, 1'b1);
    end
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);
    chk("sat_cnt4", 32'(ecnt_s), 32'd15);
    chk("sat_cnt16", 32'(ecnt), 32'd20);
    tick(1'b1, 16'h0002, 16'h0008, 1'b1);
    tick(1'b1, 16'h0000, 16'h0000, 1'b0);
    chk("sat_hold", 32'(ecnt_s), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
